// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-add/full-subtract cell, LSB first, start/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
`ifdef SERIAL_ADDSUB_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Handshake: start is sampled only in S_IDLE; done pulses for one cycle and
  // result/cout are valid from that cycle until the next done or reset.
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             bit_a, bit_b, bit_s, carry_nxt;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    bit_a     = a_q[0];
    bit_b     = b_q[0];
    bit_s     = bit_a ^ bit_b ^ carry_q;
    carry_nxt = mode_q ? ((~bit_a & bit_b) | (carry_q & ~(bit_a ^ bit_b)))
                       : ((bit_a & bit_b) | (carry_q & (bit_a ^ bit_b)));
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {bit_s, sum_q[WIDTH-1:1]};
        carry_d = carry_nxt;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = S_DONE;
          result_d = {bit_s, sum_q[WIDTH-1:1]};
          cout_d   = carry_nxt;
`ifdef SERIAL_ADDSUB_OVF_EN
          // carry_q here is the carry/borrow into the MSB
          ovf_d    = carry_q ^ carry_nxt;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign dbg_state = state_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: reference-model scoreboard, latency/handshake checks,
// reset mid-operation, ignored start and back-to-back operation.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic [1:0]   dbg_state;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  // Expected entry: {ovf, cout, result}
  logic [W+1:0] exp_q[$];

  serial_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cout      (cout),
`ifdef SERIAL_ADDSUB_OVF_EN
    .ovf       (ovf),
`endif
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0]   r;
    logic         v;
    if (!m) begin
      r = {1'b0, x} + {1'b0, y};
      v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      r = {1'b0, x} - {1'b0, y};
      v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end
    return {v, r[W], r[W-1:0]};
  endfunction

  // Scoreboard: compare every done pulse against the oldest expected entry
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (!rst && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("result", result, e[W-1:0]);
        check("cout", cout, e[W]);
`ifdef SERIAL_ADDSUB_OVF_EN
        check("ovf", ovf, e[W+1]);
`endif
      end
    end
  end

  // Driver tasks
  task automatic start_op(input bit push, input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    a     = x;
    b     = y;
    if (push) exp_q.push_back(model(m, x, y));
    @(negedge clk);
    start = 1'b0;
    mode  = 1'($urandom_range(0, 1));
    a     = W'($urandom_range(0, 255));
    b     = W'($urandom_range(0, 255));
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
    int lat;
    start_op(1'b1, m, x, y);
    check("busy_run", busy, 1);
    wait_done(lat);
    check("latency", lat, W + 1);
    check("busy_done", busy, 1);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    int lat;
    int d0;
    int n;
    int guard;
    int last;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;

    // Directed vectors
    do_op(1'b0, 8'h5A, 8'h3C);
    do_op(1'b0, 8'hFF, 8'h01);
    do_op(1'b1, 8'h10, 8'h01);
    do_op(1'b1, 8'h00, 8'h01);

    // start during RUN is ignored
    d0 = done_cnt;
    start_op(1'b1, 1'b0, 8'h01, 8'h01);
    @(negedge clk);
    start = 1'b1;
    a     = 8'h55;
    b     = 8'h22;
    mode  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("ign_latency", lat, W - 1);
    repeat (12) @(negedge clk);
    check("ign_done_count", done_cnt - d0, 1);
    do_op(1'b0, 8'h33, 8'h44);

    // Reset in the middle of RUN discards the operation
    start_op(1'b0, 1'b0, 8'h5A, 8'h3C);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_cout", cout, 0);
`ifdef SERIAL_ADDSUB_OVF_EN
    check("mid_rst_ovf", ovf, 0);
`endif
    do_op(1'b1, 8'h80, 8'h01);

    // Back-to-back with start held high
    for (int i = 0; i < 3; i++) exp_q.push_back(model(1'b0, 8'h7F, 8'h01));
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b0;
    a     = 8'h7F;
    b     = 8'h01;
    n     = 0;
    guard = 0;
    last  = 0;
    while (n < 3 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (done) begin
        if (n > 0) check("b2b_period", guard - last, W + 2);
        last = guard;
        n++;
        if (n == 3) start = 1'b0;
      end
    end
    check("b2b_count", n, 3);
    repeat (3) @(negedge clk);

    // Random operations
    for (int i = 0; i < 10; i++) begin
      do_op(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    end

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
